// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns architectural HI/LO, sequences multi-cycle
// mult/div with a fixed busy window, and serves single-cycle mfhi/mflo/mthi/mtlo.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic        start,
    output logic        busy,
    output logic [31:0] md_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;
    logic [31:0]      pend_hi_reg, pend_hi_next;
    logic [31:0]      pend_lo_reg, pend_lo_next;
    logic             pend_wr_reg, pend_wr_next;

    logic        is_mult;
    logic        is_div;
    logic        div_zero;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] divisor_u;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [31:0] quo_m;
    logic [31:0] rem_m;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign is_mult  = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign is_div   = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign start    = (state_reg == IDLE) && (is_mult || is_div);
    assign busy     = (state_reg == BUSY);
    assign div_zero = (data2 == 32'd0);

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign prod_s = {{32{data1[31]}}, data1} * {{32{data2[31]}}, data2};
    assign prod_u = {32'd0, data1} * {32'd0, data2};

    // A zero divisor is swapped for 1 so no divide-by-zero is ever evaluated;
    // that result is never committed anyway.
    assign divisor_u = div_zero ? 32'd1 : data2;
    assign quo_u     = data1 / divisor_u;
    assign rem_u     = data1 % divisor_u;

    // Signed divide on magnitudes avoids the INT_MIN / -1 overflow trap.
    assign mag1  = data1[31] ? (~data1 + 32'd1) : data1;
    assign mag2  = data2[31] ? (~data2 + 32'd1) : divisor_u;
    assign quo_m = mag1 / mag2;
    assign rem_m = mag1 % mag2;
    assign quo_s = (data1[31] ^ data2[31]) ? (~quo_m + 32'd1) : quo_m;
    assign rem_s = data1[31] ? (~rem_m + 32'd1) : rem_m;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (md_op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV:   begin res_hi = rem_s; res_lo = quo_s; end
            OP_DIVU:  begin res_hi = rem_u; res_lo = quo_u; end
            default:  ;
        endcase
    end

    always_comb begin
        md_out = 32'd0;
        case (md_op)
            OP_MFHI: md_out = hi_reg;
            OP_MFLO: md_out = lo_reg;
            default: ;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        pend_wr_next = pend_wr_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    pend_hi_next = res_hi;
                    pend_lo_next = res_lo;
                    pend_wr_next = is_mult || !div_zero;
                    cnt_next     = is_mult ? MULT_LOAD : DIV_LOAD;
                    state_next   = BUSY;
                end else if (md_op == OP_MTHI) begin
                    hi_next = data1;
                end else if (md_op == OP_MTLO) begin
                    lo_next = data1;
                end
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                    if (pend_wr_reg) begin
                        hi_next = pend_hi_reg;
                        lo_next = pend_lo_reg;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            pend_hi_reg <= 32'd0;
            pend_lo_reg <= 32'd0;
            pend_wr_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
            pend_wr_reg <= pend_wr_next;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: vector table for arithmetic and busy length,
// scoreboard for committed HI/LO, plus hand-written multi-cycle corner cases.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] data1 = 32'd0;
    logic [31:0] data2 = 32'd0;
    logic        start;
    logic        busy;
    logic [31:0] md_out;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .md_op  (md_op),
        .data1  (data1),
        .data2  (data2),
        .start  (start),
        .busy   (busy),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        md_op = 4'd5;
        #1 hi = md_out;
        md_op = 4'd6;
        #1 lo = md_out;
        md_op = 4'd0;
    endtask

    // Issues an op in the current cycle, waits out busy, then checks HI/LO
    // against the scoreboard entry; returns in the first idle cycle.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] ehi,
                          input logic [31:0] elo, input int ecyc);
        int          n;
        exp_t        e;
        logic [31:0] hi;
        logic [31:0] lo;
        md_op = op;
        data1 = d1;
        data2 = d2;
        #1 check({name, " start"}, {31'd0, start}, 32'd1);
        sb.push_back('{name, ehi, elo, ecyc});
        step();
        md_op = 4'd0;
        n = 0;
        while (busy && n < 64) begin
            n++;
            step();
        end
        read_hilo(hi, lo);
        e = sb.pop_front();
        check({e.name, " busy_cycles"}, n, e.cyc);
        check({e.name, " hi"}, hi, e.hi);
        check({e.name, " lo"}, lo, e.lo);
        $display("[TB] %s op=%0d d1=%h d2=%h -> hi=%h lo=%h busy=%0d",
                 name, op, d1, d2, hi, lo, n);
    endtask

    initial begin
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;

        vecs[0] = '{"mult_neg",    4'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1] = '{"multu_big",   4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2] = '{"div_neg",     4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{"divu_7_2",    4'd4, 32'd7,        32'd2,        32'd1,        32'd3,        10};
        vecs[4] = '{"div_ovf",     4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
        vecs[5] = '{"mult_min2",   4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        5};
        vecs[6] = '{"multu_max2",  4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[7] = '{"div_negdiv",  4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
        vecs[8] = '{"divu_big",    4'd4, 32'hFFFFFFFF, 32'd16,       32'd15,       32'h0FFFFFFF, 10};
        vecs[9] = '{"div_small",   4'd3, 32'd5,        32'd7,        32'd5,        32'd0,        10};

        step();
        step();
        reset = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset start", {31'd0, start}, 32'd0);
        check("reset md_out", md_out, 32'd0);
        read_hilo(hi, lo);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);

        for (int i = 0; i < 10; i++) begin
            step();
            run_op(vecs[i].name, vecs[i].op, vecs[i].d1, vecs[i].d2,
                   vecs[i].hi, vecs[i].lo, vecs[i].cyc);
        end

        // mflo every cycle of a mult window: old LO until T+6
        step();
        md_op = 4'd8;
        data1 = 32'hAAAA5555;
        step();
        md_op = 4'd1;
        data1 = 32'd3;
        data2 = 32'd4;
        #1 check("mflo_win start", {31'd0, start}, 32'd1);
        check("mflo_win md_out_T", md_out, 32'd0);
        for (int i = 1; i <= 6; i++) begin
            step();
            md_op = 4'd6;
            #1;
            check($sformatf("mflo_win lo_T+%0d", i), md_out, (i <= 5) ? 32'hAAAA5555 : 32'd12);
            check($sformatf("mflo_win busy_T+%0d", i), {31'd0, busy}, (i <= 5) ? 32'd1 : 32'd0);
        end
        md_op = 4'd0;
        $display("[TB] mflo_window done lo=%h", md_out);

        // divide by zero leaves HI/LO alone; ops during busy are ignored
        step();
        md_op = 4'd7;
        data1 = 32'h11111111;
        step();
        md_op = 4'd3;
        data1 = 32'd5;
        data2 = 32'd0;
        #1 check("div0 start", {31'd0, start}, 32'd1);
        step();
        n = 0;
        while (busy && n < 64) begin
            n++;
            md_op = 4'd0;
            if (n == 2) begin
                md_op = 4'd7;
                data1 = 32'h22222222;
            end else if (n == 3) begin
                md_op = 4'd1;
                data1 = 32'd3;
                data2 = 32'd4;
                #1 check("busy start_ignored", {31'd0, start}, 32'd0);
            end else if (n == 4) begin
                md_op = 4'd5;
                #1 check("busy mfhi_arch", md_out, 32'h11111111);
            end
            step();
        end
        md_op = 4'd0;
        check("div0 busy_cycles", n, 32'd10);
        read_hilo(hi, lo);
        check("div0 hi", hi, 32'h11111111);
        check("div0 lo", lo, 32'd12);
        $display("[TB] div0 hi=%h lo=%h busy=%0d", hi, lo, n);
        step();
        md_op = 4'd7;
        data1 = 32'h22222222;
        step();
        md_op = 4'd5;
        #1 check("mthi_after hi", md_out, 32'h22222222);
        md_op = 4'd0;
        $display("[TB] mthi hi=%h", md_out);

        // reset mid-operation discards the pending result
        step();
        md_op = 4'd1;
        data1 = 32'd3;
        data2 = 32'd4;
        step();
        md_op = 4'd0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid busy", {31'd0, busy}, 32'd0);
        read_hilo(hi, lo);
        check("rst_mid hi", hi, 32'd0);
        check("rst_mid lo", lo, 32'd0);
        for (int i = 0; i < 8; i++) step();
        read_hilo(hi, lo);
        check("rst_mid no_commit hi", hi, 32'd0);
        check("rst_mid no_commit lo", lo, 32'd0);
        $display("[TB] reset_mid hi=%h lo=%h", hi, lo);

        // start coinciding with reset is dropped
        md_op = 4'd1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        md_op = 4'd0;
        check("rst_start busy", {31'd0, busy}, 32'd0);
        $display("[TB] reset_with_start busy=%0d", busy);
        step();
        run_op("mult_3x4", 4'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5);

        // back-to-back: second start issued in the first idle cycle
        step();
        run_op("b2b_multu", 4'd2, 32'd5, 32'd6, 32'd0, 32'd30, 5);
        run_op("b2b_divu", 4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
